ysyx_22040237_mdu: RTL

- Parametrised iterative multiply/divide execute unit implementing RV64M (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU plus the W forms).
- Sits beside the single-cycle ALU in the execute stage. It handles the M-extension opcodes the ALU does not, over a valid/ready handshake, so the pipeline control can stall on it.
- Radix-2 shift-add multiply and restoring divide, one bit per cycle. Provides a flush for pipeline kill.

---
 rtl/ysyx_22040237_mdu.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/ysyx_22040237_mdu.sv
// ysyx_22040237_mdu: iterative RV64M multiply/divide execute unit.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle.
module ysyx_22040237_mdu #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nx;

    logic             accept, special, last;
    logic [CW-1:0]    cnt, last_cnt;
    logic [XLEN-1:0]  hi, lo, md, res;
    logic [XLEN-1:0]  nhi, nlo, fix, spec_val;
    logic             is_div, rem_sel, hi_sel, neg_q, neg_r, w;
    logic [TAG_W-1:0] tag;

    logic             w_op, div_op, zx, a_sgn, b_sgn, sa, sb;
    logic             illegal, dz, ovf;
    logic [2:0]       f3;
    logic [XLEN-1:0]  a_ext, b_ext, mag_a, mag_b;

    logic [XLEN:0]    msum, dsh;
    logic [XLEN-1:0]  ddiff, qv, rv, dv;
    logic             dge;
    logic [2*XLEN-1:0] prod;
    logic [31:0]      wp;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    assign accept   = in_valid && in_ready && !flush;
    assign last     = (cnt == last_cnt);
    assign out_data = res;
    assign out_tag  = tag;

    // decode a request into extended operands, magnitudes and one-cycle cases
    always_comb begin
        f3     = in_op[2:0];
        w_op   = in_op[3];
        div_op = f3[2];
        zx     = w_op && div_op && f3[0];
        a_ext  = in_a;
        b_ext  = in_b;
        if (w_op) begin
            a_ext = zx ? XLEN'(in_a[31:0]) : sext32(in_a[31:0]);
            b_ext = zx ? XLEN'(in_b[31:0]) : sext32(in_b[31:0]);
        end
        a_sgn   = div_op ? !f3[0] : (f3 != 3'b011);
        b_sgn   = div_op ? !f3[0] : !f3[1];
        sa      = a_sgn && a_ext[XLEN-1];
        sb      = b_sgn && b_ext[XLEN-1];
        mag_a   = sa ? -a_ext : a_ext;
        mag_b   = sb ? -b_ext : b_ext;
        illegal = w_op && (XLEN == 32 || (!div_op && f3[1:0] != 2'b00));
        dz      = div_op && (b_ext == '0);
        ovf     = div_op && !f3[0] && (b_ext == '1) &&
                  (w_op ? (in_a[31:0] == 32'h8000_0000) : (a_ext == MIN));
        special = illegal || dz || ovf;
        spec_val = '0;
        if (illegal)
            spec_val = '0;
        else if (dz)
            spec_val = f3[1] ? a_ext : '1;
        else if (ovf)
            spec_val = f3[1] ? '0 : a_ext;
        if (w_op)
            spec_val = sext32(spec_val[31:0]);
    end

    // one iteration of shift-add multiply or restoring divide
    always_comb begin
        msum  = {1'b0, hi} + (lo[0] ? {1'b0, md} : '0);
        dsh   = {hi, lo[XLEN-1]};
        dge   = (dsh >= {1'b0, md});
        ddiff = dsh[XLEN-1:0] - md;
        if (is_div) begin
            nhi = dge ? ddiff : dsh[XLEN-1:0];
            nlo = {lo[XLEN-2:0], dge};
        end else begin
            nhi = msum[XLEN:1];
            nlo = {msum[0], lo[XLEN-1:1]};
        end
    end

    // apply signs and select the architectural result from the last step
    always_comb begin
        prod = {nhi, nlo};
        if (neg_q)
            prod = -prod;
        qv = neg_q ? -nlo : nlo;
        rv = neg_r ? -nhi : nhi;
        wp = nlo[XLEN-1 -: 32];
        if (neg_q)
            wp = -wp;
        dv = rem_sel ? rv : qv;
        if (is_div)
            fix = w ? sext32(dv[31:0]) : dv;
        else if (w)
            fix = sext32(wp);
        else
            fix = hi_sel ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // next state; flush overrides every other transition
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = special ? DONE : BUSY;
            BUSY:    if (last) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush)
            state_nx = IDLE;
    end

    // handshake outputs decoded from state
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // datapath: load operands on accept, iterate while busy
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt      <= '0;
            last_cnt <= '0;
            hi       <= '0;
            lo       <= '0;
            md       <= '0;
            res      <= '0;
            tag      <= '0;
            is_div   <= 1'b0;
            rem_sel  <= 1'b0;
            hi_sel   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            w        <= 1'b0;
        end else if (accept) begin
            cnt      <= '0;
            last_cnt <= w_op ? CW'(31) : CW'(XLEN-1);
            tag      <= in_tag;
            is_div   <= div_op;
            rem_sel  <= f3[1];
            hi_sel   <= (f3[1:0] != 2'b00);
            neg_q    <= sa ^ sb;
            neg_r    <= sa;
            w        <= w_op;
            hi       <= '0;
            md       <= div_op ? mag_b : mag_a;
            if (div_op)
                lo <= w_op ? (mag_a << (XLEN-32)) : mag_a;
            else
                lo <= mag_b;
            if (special)
                res <= spec_val;
        end else if (state == BUSY && !flush) begin
            hi  <= nhi;
            lo  <= nlo;
            cnt <= cnt + 1'b1;
            if (last)
                res <= fix;
        end
    end
endmodule
